// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and sizes for the register-file write-back controller.
// WB_ROUND_ROBIN_EN (in the top) selects round-robin instead of fixed MEM-first arbitration.
package regfile_wb_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_req_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    return NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy bitmap of destination registers claimed at issue and not yet written back.
// Register 0 is never busy; a set and a clear of the same bit on one edge leaves it set.
module wb_scoreboard #(
  parameter int unsigned NumRegs = 8,
  parameter int unsigned AddrW   = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               set_i,
  input  logic [AddrW-1:0]   set_addr_i,
  input  logic               clr_i,
  input  logic [AddrW-1:0]   clr_addr_i,
  output logic [NumRegs-1:0] busy_o
);

  logic [NumRegs-1:0] busy_q, busy_d;
  logic [NumRegs-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_i) set_mask = NumRegs'(1) << set_addr_i;
    if (clr_i) clr_mask = NumRegs'(1) << clr_addr_i;
    // The new producer owns the register, so set overrides clear.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Shares the register file write port between the ALU and load unit and tracks pending writes.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise MEM has fixed priority.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned XLEN       = regfile_wb_ctrl_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = regfile_wb_ctrl_pkg::REG_ADDR_W,
  parameter int unsigned NUM_REGS   = regfile_wb_ctrl_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_value,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_value,
  output logic                  mem_ready,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       rd_value,
  output logic [NUM_REGS-1:0]   busy
);

  logic                  grant_alu, grant_mem;
  logic                  accept;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_value;

  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       value_q, value_d;

`ifdef WB_ROUND_ROBIN_EN
  wb_req_e prio_q, prio_d;

  always_comb begin
    grant_mem = mem_valid & (~alu_valid | (prio_q == WB_MEM));
    grant_alu = alu_valid & (~mem_valid | (prio_q == WB_ALU));
    prio_d    = prio_q;
    // Point at whoever was not granted so a loser waits at most one cycle.
    if (grant_alu) begin
      prio_d = WB_MEM;
    end else if (grant_mem) begin
      prio_d = WB_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= WB_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  always_comb begin
    grant_mem = mem_valid;
    grant_alu = alu_valid & ~mem_valid;
  end
`endif

  // Gated by reset so no handshake completes while the controller is held in reset.
  assign alu_ready = rst_n & grant_alu;
  assign mem_ready = rst_n & grant_mem;

  always_comb begin
    accept    = grant_alu | grant_mem;
    sel_rd    = grant_mem ? mem_rd : alu_rd;
    sel_value = grant_mem ? mem_value : alu_value;
    wen_d     = 1'b0;
    rd_d      = rd_q;
    value_d   = value_q;
    if (accept) begin
      wen_d   = (sel_rd != '0);
      rd_d    = sel_rd;
      value_d = sel_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      rd_q    <= '0;
      value_q <= '0;
    end else begin
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      value_q <= value_d;
    end
  end

  assign reg_write_en = wen_q;
  assign rd           = rd_q;
  assign rd_value     = value_q;

  wb_scoreboard #(
    .NumRegs (NUM_REGS),
    .AddrW   (REG_ADDR_W)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .set_i      (issue_valid & (issue_rd != '0)),
    .set_addr_i (issue_rd),
    .clr_i      (wen_q),
    .clr_addr_i (rd_q),
    .busy_o     (busy)
  );

endmodule
